// File: rtl/d_reg_bank_if.sv
// rtl/d_reg_bank_if.sv - load/commit/status bundle for the multi-channel register bank
interface d_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    logic                   mode;
    logic [NCH-1:0]         en;
    logic [NCH*WIDTH-1:0]   d;
    logic                   commit;
    logic                   clr;
    logic [NCH*WIDTH-1:0]   q;
    logic [NCH-1:0]         dirty;
    logic [NCH-1:0]         stale;
    logic                   commit_ack;

    modport master (
        output mode, en, d, commit, clr,
        input  q, dirty, stale, commit_ack
    );

    modport slave (
        input  mode, en, d, commit, clr,
        output q, dirty, stale, commit_ack
    );
endinterface

// File: rtl/d_reg_bank.sv
// rtl/d_reg_bank.sv - per-channel shadow/commit register bank with staleness tracking
module d_reg_bank #(
    parameter int WIDTH       = 8,
    parameter int NCH         = 4,
    parameter int STALE_LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    d_reg_bank_if.slave  bus
);
    localparam int AW = $clog2(STALE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(STALE_LIMIT);

    logic [WIDTH-1:0] shadow_r [NCH];
    logic [WIDTH-1:0] shadow_n [NCH];
    logic [WIDTH-1:0] q_r      [NCH];
    logic [WIDTH-1:0] q_n      [NCH];
    logic [AW-1:0]    age_r    [NCH];
    logic [AW-1:0]    age_n    [NCH];
    logic [NCH-1:0]   dirty_r;
    logic [NCH-1:0]   dirty_n;
    logic [NCH-1:0]   q_wr;
    logic             ack_r;

    // Per-channel next state: a load on the same edge as a commit wins over the
    // older shadow contents, and any q write restarts that channel's age.
    always_comb begin
        dirty_n = dirty_r;
        q_wr    = '0;
        for (int i = 0; i < NCH; i++) begin
            shadow_n[i] = shadow_r[i];
            q_n[i]      = q_r[i];
            if (bus.en[i]) begin
                shadow_n[i] = bus.d[i*WIDTH +: WIDTH];
                if (bus.mode || bus.commit) begin
                    q_n[i]     = bus.d[i*WIDTH +: WIDTH];
                    dirty_n[i] = 1'b0;
                    q_wr[i]    = 1'b1;
                end else begin
                    dirty_n[i] = 1'b1;
                end
            end else if (bus.commit && dirty_r[i]) begin
                q_n[i]     = shadow_r[i];
                dirty_n[i] = 1'b0;
                q_wr[i]    = 1'b1;
            end
            if (q_wr[i]) begin
                age_n[i] = '0;
            end else if (age_r[i] == AGE_MAX) begin
                age_n[i] = age_r[i];
            end else begin
                age_n[i] = age_r[i] + AW'(1);
            end
        end
    end

    // State registers; reset and clear both return everything to idle and
    // suppress the ack for a commit sampled on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            dirty_r <= '0;
            ack_r   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_r[i] <= '0;
                q_r[i]      <= '0;
                age_r[i]    <= '0;
            end
        end else begin
            dirty_r <= dirty_n;
            ack_r   <= bus.commit;
            for (int i = 0; i < NCH; i++) begin
                shadow_r[i] <= shadow_n[i];
                q_r[i]      <= q_n[i];
                age_r[i]    <= age_n[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_out
            assign bus.q[g*WIDTH +: WIDTH] = q_r[g];
            assign bus.stale[g]            = (age_r[g] == AGE_MAX);
        end
    endgenerate

    assign bus.dirty      = dirty_r;
    assign bus.commit_ack = ack_r;
endmodule

// File: tb/tb_d_reg_bank.sv
// tb/tb_d_reg_bank.sv - self-checking bench for d_reg_bank
module tb_d_reg_bank;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    d_reg_bank_if #(.WIDTH(8), .NCH(4)) bus_a ();
    d_reg_bank_if #(.WIDTH(8), .NCH(4)) bus_b ();

    d_reg_bank #(.WIDTH(8), .NCH(4), .STALE_LIMIT(15)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    d_reg_bank #(.WIDTH(8), .NCH(4), .STALE_LIMIT(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_b.mode   = bus_a.mode;
    assign bus_b.en     = bus_a.en;
    assign bus_b.d      = bus_a.d;
    assign bus_b.commit = bus_a.commit;
    assign bus_b.clr    = bus_a.clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] m_q  [4];
    logic [7:0] m_sh [4];
    bit         m_dirty [4];
    int         m_since [4];
    bit         m_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_n || bus_a.clr) begin
            m_ack = 0;
            for (int i = 0; i < 4; i++) begin
                m_q[i] = 0; m_sh[i] = 0; m_dirty[i] = 0; m_since[i] = 0;
            end
        end else begin
            m_ack = bus_a.commit;
            for (int i = 0; i < 4; i++) begin
                logic [7:0] di;
                bit wr;
                di = bus_a.d[i*8 +: 8];
                wr = 0;
                if (bus_a.en[i]) begin
                    m_sh[i] = di;
                    if (bus_a.mode || bus_a.commit) begin
                        m_q[i] = di; m_dirty[i] = 0; wr = 1;
                    end else begin
                        m_dirty[i] = 1;
                    end
                end else if (bus_a.commit && m_dirty[i]) begin
                    m_q[i] = m_sh[i]; m_dirty[i] = 0; wr = 1;
                end
                if (wr) m_since[i] = 0;
                else if (m_since[i] < 1000) m_since[i]++;
            end
        end
    endtask

    function automatic logic [31:0] exp_q();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_q[i];
        return r;
    endfunction

    function automatic logic [3:0] exp_dirty();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_dirty[i];
        return r;
    endfunction

    function automatic logic [3:0] exp_stale(input int limit);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_since[i] >= limit);
        return r;
    endfunction

    task automatic check_model();
        chk("q_a",     bus_a.q,          exp_q());
        chk("dirty_a", bus_a.dirty,      exp_dirty());
        chk("ack_a",   bus_a.commit_ack, m_ack);
        chk("stale_a", bus_a.stale,      exp_stale(15));
        chk("q_b",     bus_b.q,          exp_q());
        chk("dirty_b", bus_b.dirty,      exp_dirty());
        chk("ack_b",   bus_b.commit_ack, m_ack);
        chk("stale_b", bus_b.stale,      exp_stale(3));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        bus_a.en     = '0;
        bus_a.commit = 1'b0;
        bus_a.clr    = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus_a.mode = 1'b0;
        bus_a.d    = '0;
        idle();

        // reset and default staleness
        cycle();
        cycle();
        chk("rst_q", bus_a.q, 32'h0);
        chk("rst_dirty", bus_a.dirty, 4'h0);
        chk("rst_ack", bus_a.commit_ack, 1'b0);
        chk("rst_stale", bus_a.stale, 4'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (k == 13) chk("stale_a_14", bus_a.stale, 4'h0);
            if (k == 14) chk("stale_a_15", bus_a.stale, 4'hF);
        end

        // staged load then commit
        bus_a.mode = 1'b0;
        bus_a.en   = 4'b0101;
        bus_a.d    = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        cycle();
        chk("staged_dirty", bus_a.dirty, 4'b0101);
        chk("staged_q", bus_a.q, 32'h0);
        idle();
        bus_a.commit = 1'b1;
        cycle();
        chk("commit_q", bus_a.q, 32'h00CC00AA);
        chk("commit_dirty", bus_a.dirty, 4'h0);
        chk("commit_ack", bus_a.commit_ack, 1'b1);
        idle();
        cycle();
        chk("ack_single", bus_a.commit_ack, 1'b0);

        // simultaneous load and commit on a dirty channel
        bus_a.en = 4'b0010;
        bus_a.d  = 32'h00001100;
        cycle();
        chk("sim_pre_dirty", bus_a.dirty[1], 1'b1);
        bus_a.d      = 32'h00002200;
        bus_a.commit = 1'b1;
        cycle();
        chk("sim_q1", bus_a.q[15:8], 8'h22);
        chk("sim_dirty1", bus_a.dirty[1], 1'b0);
        chk("sim_ack", bus_a.commit_ack, 1'b1);
        idle();

        // direct mode and mode switch
        bus_a.en = 4'b1000;
        bus_a.d  = 32'h5A000000;
        cycle();
        bus_a.mode = 1'b1;
        bus_a.en   = 4'b0001;
        bus_a.d    = 32'h00000077;
        cycle();
        chk("direct_q0", bus_a.q[7:0], 8'h77);
        chk("switch_dirty3", bus_a.dirty[3], 1'b1);
        chk("switch_q3", bus_a.q[31:24], 8'h00);
        idle();
        bus_a.commit = 1'b1;
        cycle();
        chk("switch_commit_q3", bus_a.q[31:24], 8'h5A);
        idle();
        cycle();

        // clear, then reset, with everything dirty and a commit pending
        for (int pass = 0; pass < 2; pass++) begin
            bus_a.mode = 1'b1;
            bus_a.en   = 4'hF;
            bus_a.d    = $urandom | 32'h01010101;
            cycle();
            bus_a.mode = 1'b0;
            bus_a.d    = $urandom;
            cycle();
            chk("pre_clr_dirty", bus_a.dirty, 4'hF);
            bus_a.en     = '0;
            bus_a.commit = 1'b1;
            if (pass == 0) bus_a.clr = 1'b1;
            else           rst_n     = 1'b0;
            cycle();
            chk("clr_q", bus_a.q, 32'h0);
            chk("clr_dirty", bus_a.dirty, 4'h0);
            chk("clr_ack", bus_a.commit_ack, 1'b0);
            rst_n = 1'b1;
            idle();
        end

        // staleness at STALE_LIMIT=3
        bus_a.mode = 1'b1;
        bus_a.en   = 4'b0100;
        bus_a.d    = 32'h00330000;
        cycle();
        chk("stale3_wr", bus_b.stale[2], 1'b0);
        idle();
        cycle();
        chk("stale3_e1", bus_b.stale[2], 1'b0);
        cycle();
        chk("stale3_e2", bus_b.stale[2], 1'b0);
        cycle();
        chk("stale3_e3", bus_b.stale[2], 1'b1);
        cycle();
        cycle();
        chk("stale3_hold", bus_b.stale[2], 1'b1);
        bus_a.en = 4'b0100;
        bus_a.d  = 32'h00440000;
        cycle();
        chk("stale3_drop", bus_b.stale[2], 1'b0);
        idle();

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bus_a.mode   = $urandom_range(0, 3) == 0;
            bus_a.en     = 4'($urandom);
            if ($urandom_range(0, 1) == 0) bus_a.en = '0;
            bus_a.d      = $urandom;
            bus_a.commit = $urandom_range(0, 4) == 0;
            bus_a.clr    = $urandom_range(0, 40) == 0;
            rst_n        = $urandom_range(0, 60) != 0;
            cycle();
        end
        rst_n = 1'b1;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/d_reg_bank.md
# d_reg_bank

Parametrised multi-channel data-holding register bank. It succeeds the single-bit enable latch and replaces level-sensitive transparency with clocked, per-channel load enables. Each channel has a shadow stage with an atomic commit, a direct (write-through) mode, synchronous clear, and per-channel staleness tracking. It sits between producers that update channel data independently and consumers that require all channels to change on the same edge.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- NCH, 4, number of channels (≥1)
- STALE_LIMIT, 15, cycles without a q update before a channel reports stale (≥1)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- mode  in  1  0 = staged (load to shadow, commit to q); 1 = direct (load goes to q)
- en  in  NCH  per-channel load enable; en[i] qualifies d slice i
- d  in  NCH*WIDTH  input data; channel i = d[i*WIDTH +: WIDTH]
- commit  in  1  transfer all dirty shadows to q
- clr  in  1  synchronous clear of all data and status
- q  out  NCH*WIDTH  held output data; channel i = q[i*WIDTH +: WIDTH]
- dirty  out  NCH  shadow[i] holds data not yet committed to q[i]
- stale  out  NCH  q[i] unchanged for STALE_LIMIT or more cycles
- commit_ack  out  1  one-cycle pulse confirming a sampled commit

## Operation
- Priority at each edge: rst_n=0, then clr=1, then normal operation.
- Reset: shadow=0, q=0, dirty=0, age=0, commit_ack=0. stale therefore reads 0.
- clr=1: same state as reset. commit, en, and mode are ignored that cycle.
- Staged load (mode=0, en[i]=1, commit=0): shadow[i] takes the d slice and dirty[i] is set. q[i] is unchanged.
- Direct load (mode=1, en[i]=1): q[i] and shadow[i] both take the d slice. dirty[i] is cleared.
- Commit (commit=1, either mode): for every i with dirty[i]=1, q[i] takes shadow[i] and dirty[i] is cleared. Channels that are not dirty are untouched.
- Load and commit in the same cycle on channel i: the newest data wins. q[i] and shadow[i] both take the d slice, and dirty[i] ends at 0.
- Mode changes never discard data.
  - Dirty channels stay dirty across a 0→1 switch until a commit occurs or a direct load overwrites them.
  - A 1→0 switch leaves q as is.
- commit_ack is registered: it is 1 in the cycle after commit is sampled, including when no channel is dirty. It is 0 otherwise.
- Back-to-back commit cycles produce back-to-back ack cycles.
- Age counters:
  - Each channel has a saturating counter of width clog2(STALE_LIMIT+1).
  - The counter clears to 0 on any edge that writes q[i] (direct load, or commit of a dirty channel). Otherwise it increments, saturating at STALE_LIMIT.
  - stale[i] = (age[i] == STALE_LIMIT), decoded from registered state.
- Widths: no arithmetic on data. Counters never wrap.

## Timing
- Load-to-q latency:
  - Direct mode: 1 edge.
  - Staged mode: shadow after 1 edge, q on the commit edge.
- dirty and q update on the same edge as the causing input. commit_ack lags the commit edge by 1 cycle.
- stale[i] asserts exactly STALE_LIMIT edges after the last q[i] write with no intervening write. It deasserts on the edge that writes q[i].
- After reset is released, stale[i] asserts STALE_LIMIT edges later unless channel i is written first.
- Reset or clr asserted mid-operation (pending dirty data, or commit in the same cycle): all state goes to reset values and no commit_ack is produced for that cycle.
- All outputs are registered or decoded purely from registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset, defaults: hold rst_n=0 for 2 edges, then release. Required: q=0, dirty=0, commit_ack=0. stale=4'hF exactly 15 edges after release.
- Staged load then commit: mode=0, en=4'b0101, d={8'hDD,8'hCC,8'hBB,8'hAA}. Required: dirty=4'b0101 and q unchanged. Then commit=1. Required: q[0]=AA and q[2]=CC on that edge, dirty=0, commit_ack=1 on the next cycle only.
- Simultaneous load and commit: channel 1 dirty with 8'h11. In one cycle apply en[1]=1, d slice 8'h22, commit=1. Required: q[1]=22, dirty[1]=0, ack pulse.
- Direct mode and mode switch: stage 8'h5A on channel 3 in mode 0, then switch to mode=1 and load channel 0 with 8'h77. Required: q[0]=77 after 1 edge, dirty[3] stays 1, and q[3]=5A after commit.
- Clear and reset mid-operation: with dirty=4'b1111, assert commit and clr together. Required: q=0, dirty=0, no ack. Repeat with rst_n=0 instead of clr; same result.
- Staleness: STALE_LIMIT=3, write channel 2 once. Required: stale[2]=1 exactly 3 edges later, stays 1 while unwritten, and drops on the edge of a direct load.
